serial_mag_comp: RTL and testbench
==================================

// Module: serial_mag_comp
// PURPOSE
//   Bit-serial, MSB-first magnitude comparator for two WIDTH-bit unsigned words.
//   Scans one bit pair per clock and reports the equal / less-than / greater-than
//   relation through a start/done handshake.
//   Gives the word-level counterpart of the single-bit eq/lt/gt compare cell.
//   Area-lean sequential datapath for sort, limit-check and arbitration logic.
// PARAMETERS
//   WIDTH  8  operand width in bits (>=2); also the scan length in cycles
// PORTS
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous, active-low reset
//   start  in   1      request compare; a/b sampled on the edge where accepted
//   a      in   WIDTH  operand A, unsigned
//   b      in   WIDTH  operand B, unsigned
//   busy   out  1      high while scanning; start is ignored when high
//   done   out  1      one-cycle pulse; eq/lt/gt are valid from this cycle on
//   eq     out  1      result: A == B
//   lt     out  1      result: A < B
//   gt     out  1      result: A > B
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - FSM->IDLE; busy=0, done=0, eq=0, lt=0, gt=0
//   - shift registers and bit counter cleared
//   FSM states: IDLE, SCAN, DONE
//   - IDLE: start=1 -> load a->sa, b->sb; cnt=WIDTH-1; work flags e=1, l=0, g=0;
//     go to SCAN.
//   - SCAN: busy=1. Each cycle, with ai=sa[MSB] and bi=sb[MSB], and only while e=1:
//     - ~ai & bi -> l=1, e=0
//     - ai & ~bi -> g=1, e=0
//     - otherwise flags unchanged
//     - after a decision the flags are sticky: no early exit, scan runs to completion.
//   - SCAN, every cycle: sa and sb shift left by 1; cnt decrements.
//   - SCAN, exit: when cnt==0 is processed, go to DONE.
//   - DONE: done=1 for exactly one cycle; eq/lt/gt <= final e/l/g on the same edge
//     that enters DONE; busy=0.
//   - DONE, next state: start=1 -> reload exactly as from IDLE (back-to-back);
//     otherwise -> IDLE.
//   Latency: start sampled at edge k -> SCAN for edges k+1..k+WIDTH ->
//     done high after edge k+WIDTH.
//     Throughput: one result per WIDTH+1 cycles.
//   Outputs: eq/lt/gt are registered and exactly one-hot after the first done.
//     They hold the last result until the next done; they do not change during SCAN.
//   Boundary conditions:
//   - start while busy: ignored; operands are not re-sampled.
//   - a/b changes after acceptance: no effect on the result in flight.
//   - start held high: a new compare is accepted in every DONE cycle.
//   - reset mid-SCAN: abort; no done pulse; outputs return to reset values.
//   - all-zero or all-one operands: eq=1 (decision never taken).
//   - Unsigned only; no sign handling.
// TESTING (WIDTH=8)
//   1 a=8'h5A, b=8'h5A, start pulse -> done 8 cycles later; eq=1 lt=0 gt=0.
//   2 a=8'h80, b=8'h7F -> gt=1 (decided on MSB); done still 8 cycles after start;
//     a=8'h00, b=8'hFF -> lt=1.
//   3 a=8'h01, b=8'h00 -> gt=1 (LSB decision); then a=8'hFE, b=8'hFF -> lt=1.
//   4 Start a=8'h10, b=8'h20; pulse start with a=8'hFF, b=8'h00 on scan cycle 3
//     -> ignored; single done; lt=1.
//   5 Drop rst_n on scan cycle 4 -> busy=0 immediately, no done, eq=lt=gt=0;
//     next compare is correct.
//   6 start held high, operand pairs (3,3), (9,4), (2,7) -> done every 9 cycles;
//     results eq, gt, lt in order; random sweep vs a==b / a<b / a>b.

Source files
------------

// File: rtl/serial_mag_comp.sv
// serial_mag_comp
// Bit-serial, MSB-first magnitude comparator for two WIDTH-bit unsigned words.
// One bit pair is examined per clock. The first differing bit decides the
// relation, and the decision is held until the scan ends. The scan always runs
// the full WIDTH cycles, so the latency does not depend on the data.
// The result (eq/lt/gt) is registered and is reported with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; the last result is held on eq/lt/gt
// SCAN  | shifting operands MSB-first; busy=1 and start is ignored
// DONE  | done=1 for one cycle; start here reloads back-to-back

module serial_mag_comp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             e_q, e_d;
    logic             l_q, l_d;
    logic             g_q, g_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;

    logic accept;
    logic last_bit;
    logic ai, bi;

    // A new compare is taken only when no scan is running.
    assign accept   = start && (state_q != S_SCAN);
    assign last_bit = (state_q == S_SCAN) && (cnt_q == '0);
    assign ai       = sa_q[WIDTH-1];
    assign bi       = sb_q[WIDTH-1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (cnt_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = start ? S_SCAN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs, decoded from the registered state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_SCAN:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: load, shift, sticky decision, result capture
    always_comb begin
        sa_d  = sa_q;
        sb_d  = sb_q;
        cnt_d = cnt_q;
        e_d   = e_q;
        l_d   = l_q;
        g_d   = g_q;
        eq_d  = eq_q;
        lt_d  = lt_q;
        gt_d  = gt_q;

        if (accept) begin
            sa_d  = a;
            sb_d  = b;
            cnt_d = CNT_LOAD;
            e_d   = 1'b1;
            l_d   = 1'b0;
            g_d   = 1'b0;
        end else if (state_q == S_SCAN) begin
            sa_d = {sa_q[WIDTH-2:0], 1'b0};
            sb_d = {sb_q[WIDTH-2:0], 1'b0};
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            // Once a bit pair differs, the relation is fixed; lower bits cannot change it.
            if (e_q) begin
                if (!ai && bi) begin
                    l_d = 1'b1;
                    e_d = 1'b0;
                end else if (ai && !bi) begin
                    g_d = 1'b1;
                    e_d = 1'b0;
                end
            end
        end

        // Publish on the edge that enters DONE, including the decision from the LSB.
        if (last_bit) begin
            eq_d = e_d;
            lt_d = l_d;
            gt_d = g_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q  <= '0;
            sb_q  <= '0;
            cnt_q <= '0;
            e_q   <= 1'b0;
            l_q   <= 1'b0;
            g_q   <= 1'b0;
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
            gt_q  <= 1'b0;
        end else begin
            sa_q  <= sa_d;
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
            e_q   <= e_d;
            l_q   <= l_d;
            g_q   <= g_d;
            eq_q  <= eq_d;
            lt_q  <= lt_d;
            gt_q  <= gt_d;
        end
    end

    assign eq = eq_q;
    assign lt = lt_q;
    assign gt = gt_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// tb_serial_mag_comp
// Scoreboard bench for serial_mag_comp (WIDTH=8). A reference model decides
// when a compare is accepted and what its result must be. It pushes each
// expectation, together with the edge on which done must appear, into a queue.
// A monitor on the falling edge checks busy, done and the held result every cycle.

module tb_serial_mag_comp;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, eq, lt, gt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  res;
        int unsigned done_edge;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned edge_idx = 0;
    int unsigned next_ok  = 0;
    logic [2:0]  last_res = 3'b000;

    serial_mag_comp #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .lt    (lt),
        .gt    (gt)
    );

    always #5 clk = ~clk;

    // Expected relation from plain unsigned arithmetic, packed as {eq, lt, gt}.
    function automatic logic [2:0] ref_cmp(input int unsigned x, input int unsigned y);
        return {x == y, x < y, x > y};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, want, edge_idx, $time);
        end
    endtask

    // Reference model. A compare is accepted if start is high and the previous
    // compare has reached its done cycle. Its result is due W edges later.
    always @(posedge clk or negedge rst_n) begin : model
        exp_t e;
        if (!rst_n) begin
            sb_q.delete();
            last_res = 3'b000;
            next_ok  = 0;
        end else begin
            edge_idx++;
            if (start && edge_idx >= next_ok) begin
                e.res       = ref_cmp(a, b);
                e.done_edge = edge_idx + W;
                sb_q.push_back(e);
                next_ok = edge_idx + W + 1;
            end
        end
    end

    // Monitor: every falling edge, compare busy/done/result with the scoreboard.
    always @(negedge clk) begin : monitor
        logic exp_busy, exp_done;
        exp_busy = (sb_q.size() > 0) && (sb_q[0].done_edge > edge_idx);
        exp_done = (sb_q.size() > 0) && (sb_q[0].done_edge == edge_idx);
        check("busy", 8'(busy), 8'(exp_busy));
        check("done", 8'(done), 8'(exp_done));
        if (exp_done) begin
            last_res = sb_q[0].res;
            void'(sb_q.pop_front());
        end
        check("result{eq,lt,gt}", 8'({eq, lt, gt}), 8'(last_res));
    end

    task automatic cmp_pulse(input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        start = 1'b1;
        a = va;
        b = vb;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        repeat (W + 1) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 8'(busy), 8'd0);
        check("reset done", 8'(done), 8'd0);
        check("reset eq/lt/gt", 8'({eq, lt, gt}), 8'd0);
        rst_n = 1'b1;

        // Directed cases: equal, MSB decision, LSB decision, extremes.
        cmp_pulse(8'h5A, 8'h5A);
        cmp_pulse(8'h80, 8'h7F);
        cmp_pulse(8'h00, 8'hFF);
        cmp_pulse(8'h01, 8'h00);
        cmp_pulse(8'hFE, 8'hFF);
        cmp_pulse(8'h00, 8'h00);
        cmp_pulse(8'hFF, 8'hFF);

        // A start pulse during the scan must be ignored.
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'h00;
        @(negedge clk);
        start = 1'b0; a = 8'h00; b = 8'hFF;
        repeat (W + 2) @(negedge clk);

        // Reset in the middle of a scan: abort, no done, outputs cleared.
        @(negedge clk);
        start = 1'b1; a = 8'hC3; b = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", 8'(busy), 8'd0);
        check("abort done", 8'(done), 8'd0);
        check("abort eq/lt/gt", 8'({eq, lt, gt}), 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cmp_pulse(8'h3C, 8'hC3);

        // start held high: back-to-back compares, one result every W+1 cycles.
        @(negedge clk);
        start = 1'b1; a = 8'd3; b = 8'd3;
        @(negedge clk);
        a = 8'd9; b = 8'd4;
        repeat (W + 1) @(negedge clk);
        a = 8'd2; b = 8'd7;
        repeat (W + 1) @(negedge clk);
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        // Random sweep: random start activity and operands every cycle.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            a = W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                a = ($urandom_range(0, 1) != 0) ? '1 : '0;
                b = a;
            end
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        check("scoreboard drained", 8'(sb_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
